// File: rtl/dbuf_latch_bank.sv
// Double-buffered channel register bank.
// Software-style writes land in a shadow bank; a commit copies the whole
// shadow bank into the active bank (Dout) in one edge, either immediately
// or deferred to the next Sync pulse. A registered readback port exposes
// either bank.
module dbuf_latch_bank #(
  parameter int unsigned WIDTH       = 48,
  parameter int unsigned CHANNELS    = 4,
  parameter int unsigned ADDR_W      = 2,
  parameter int unsigned COMMIT_MODE = 0
) (
  input  logic                      Clock,
  input  logic                      Reset,
  input  logic                      WrEn,
  input  logic [ADDR_W-1:0]         WrAddr,
  input  logic [WIDTH-1:0]          WrData,
  input  logic                      Commit,
  input  logic                      Sync,
  input  logic [ADDR_W-1:0]         RdSel,
  input  logic                      RdShadow,
  output logic [WIDTH-1:0]          RdData,
  output logic [CHANNELS*WIDTH-1:0] Dout,
  output logic                      Pending,
  output logic                      Updated
);

  typedef enum logic {
    IDLE  = 1'b0,
    ARMED = 1'b1
  } state_t;

  state_t           state;
  state_t           state_next;
  logic             transfer;
  logic [WIDTH-1:0] shadow      [CHANNELS];
  logic [WIDTH-1:0] shadow_next [CHANNELS];
  logic [WIDTH-1:0] active      [CHANNELS];
  logic [WIDTH-1:0] rd_next;

  // Commit state register: holds a deferred commit until Sync.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and transfer decision; in immediate mode the FSM is parked in IDLE.
  always_comb begin
    state_next = state;
    transfer   = 1'b0;
    if (COMMIT_MODE == 1) begin
      state_next = IDLE;
      transfer   = Commit;
    end else begin
      case (state)
        IDLE: begin
          if (Commit) begin
            if (Sync) begin
              transfer = 1'b1;
            end else begin
              state_next = ARMED;
            end
          end
        end
        ARMED: begin
          // Further Commits are absorbed; only Sync matters here.
          if (Sync) begin
            transfer   = 1'b1;
            state_next = IDLE;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // Pending flag mirrors the ARMED state.
  always_comb begin
    Pending = (state == ARMED);
  end

  // Shadow bank after this cycle's write; out-of-range addresses match no channel.
  always_comb begin
    for (int unsigned k = 0; k < CHANNELS; k++) begin
      shadow_next[k] = shadow[k];
      if (WrEn && (WrAddr == ADDR_W'(k))) begin
        shadow_next[k] = WrData;
      end
    end
  end

  // Shadow storage.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      for (int unsigned k = 0; k < CHANNELS; k++) begin
        shadow[k] <= '0;
      end
    end else begin
      for (int unsigned k = 0; k < CHANNELS; k++) begin
        shadow[k] <= shadow_next[k];
      end
    end
  end

  // Active storage: the transfer takes the shadow value including a same-cycle write.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      for (int unsigned k = 0; k < CHANNELS; k++) begin
        active[k] <= '0;
      end
    end else if (transfer) begin
      for (int unsigned k = 0; k < CHANNELS; k++) begin
        active[k] <= shadow_next[k];
      end
    end
  end

  // One-cycle Updated pulse following each transfer edge.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      Updated <= 1'b0;
    end else begin
      Updated <= transfer;
    end
  end

  // Readback select; an index beyond the last channel yields zero.
  always_comb begin
    rd_next = '0;
    for (int unsigned k = 0; k < CHANNELS; k++) begin
      if (RdSel == ADDR_W'(k)) begin
        rd_next = RdShadow ? shadow[k] : active[k];
      end
    end
  end

  // Registered readback.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      RdData <= '0;
    end else begin
      RdData <= rd_next;
    end
  end

  // Flatten the active bank onto Dout.
  always_comb begin
    Dout = '0;
    for (int unsigned k = 0; k < CHANNELS; k++) begin
      Dout[k*WIDTH +: WIDTH] = active[k];
    end
  end

endmodule

// File: tb/tb_dbuf_latch_bank.sv
// Bench for dbuf_latch_bank: three instances (deferred commit, immediate
// commit, three-channel deferred) share one stimulus stream and are each
// compared against an array-based reference model every cycle.
module tb_dbuf_latch_bank;

  logic        Clock;
  logic        Reset;
  logic        wr_en;
  logic [1:0]  wr_addr;
  logic [47:0] wr_data;
  logic        commit;
  logic        sync;
  logic [1:0]  rd_sel;
  logic        rd_shadow;

  logic [47:0]  rd0, rd1, rd2;
  logic [191:0] dout0, dout1;
  logic [143:0] dout2;
  logic         pend0, pend1, pend2;
  logic         upd0, upd1, upd2;

  int errors = 0;
  int checks = 0;

  dbuf_latch_bank #(.WIDTH(48), .CHANNELS(4), .ADDR_W(2), .COMMIT_MODE(0)) dut0 (
    .Clock(Clock), .Reset(Reset), .WrEn(wr_en), .WrAddr(wr_addr), .WrData(wr_data),
    .Commit(commit), .Sync(sync), .RdSel(rd_sel), .RdShadow(rd_shadow),
    .RdData(rd0), .Dout(dout0), .Pending(pend0), .Updated(upd0));

  dbuf_latch_bank #(.WIDTH(48), .CHANNELS(4), .ADDR_W(2), .COMMIT_MODE(1)) dut1 (
    .Clock(Clock), .Reset(Reset), .WrEn(wr_en), .WrAddr(wr_addr), .WrData(wr_data),
    .Commit(commit), .Sync(sync), .RdSel(rd_sel), .RdShadow(rd_shadow),
    .RdData(rd1), .Dout(dout1), .Pending(pend1), .Updated(upd1));

  dbuf_latch_bank #(.WIDTH(48), .CHANNELS(3), .ADDR_W(2), .COMMIT_MODE(0)) dut2 (
    .Clock(Clock), .Reset(Reset), .WrEn(wr_en), .WrAddr(wr_addr), .WrData(wr_data),
    .Commit(commit), .Sync(sync), .RdSel(rd_sel), .RdShadow(rd_shadow),
    .RdData(rd2), .Dout(dout2), .Pending(pend2), .Updated(upd2));

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // Reference model state, one slot per instance.
  int          m_ch   [3] = '{4, 4, 3};
  int          m_mode [3] = '{0, 1, 0};
  logic [47:0] m_sh   [3][4];
  logic [47:0] m_act  [3][4];
  logic [47:0] m_rd   [3];
  logic        m_pend [3];
  logic        m_upd  [3];

  task automatic check_eq(input string tag, input logic [191:0] got, input logic [191:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 3; i++) begin
      for (int k = 0; k < 4; k++) begin
        m_sh[i][k]  = '0;
        m_act[i][k] = '0;
      end
      m_rd[i]   = '0;
      m_pend[i] = 1'b0;
      m_upd[i]  = 1'b0;
    end
  endtask

  // One clock edge of behaviour for instance i, from the current inputs.
  task automatic model_step(input int i);
    logic xfer;
    int   rs;
    int   wa;
    rs = int'(rd_sel);
    wa = int'(wr_addr);
    if (rs < m_ch[i]) m_rd[i] = rd_shadow ? m_sh[i][rs] : m_act[i][rs];
    else              m_rd[i] = '0;
    if (wr_en && wa < m_ch[i]) m_sh[i][wa] = wr_data;
    if (m_mode[i] == 1) begin
      xfer = commit;
    end else if (m_pend[i]) begin
      xfer = sync;
      if (sync) m_pend[i] = 1'b0;
    end else begin
      xfer = commit && sync;
      if (commit && !sync) m_pend[i] = 1'b1;
    end
    if (xfer) begin
      for (int k = 0; k < 4; k++) m_act[i][k] = m_sh[i][k];
    end
    m_upd[i] = xfer;
  endtask

  function automatic logic [191:0] model_dout(input int i);
    logic [191:0] v;
    v = '0;
    for (int k = 0; k < m_ch[i]; k++) v[k*48 +: 48] = m_act[i][k];
    return v;
  endfunction

  task automatic check_all();
    check_eq("dout0", dout0, model_dout(0));
    check_eq("pend0", 192'(pend0), 192'(m_pend[0]));
    check_eq("upd0",  192'(upd0),  192'(m_upd[0]));
    check_eq("rd0",   192'(rd0),   192'(m_rd[0]));
    check_eq("dout1", dout1, model_dout(1));
    check_eq("pend1", 192'(pend1), 192'(m_pend[1]));
    check_eq("upd1",  192'(upd1),  192'(m_upd[1]));
    check_eq("rd1",   192'(rd1),   192'(m_rd[1]));
    check_eq("dout2", 192'(dout2), model_dout(2));
    check_eq("pend2", 192'(pend2), 192'(m_pend[2]));
    check_eq("upd2",  192'(upd2),  192'(m_upd[2]));
    check_eq("rd2",   192'(rd2),   192'(m_rd[2]));
  endtask

  task automatic cycle(input logic we, input logic [1:0] wa, input logic [47:0] wd,
                       input logic c, input logic s, input logic [1:0] rs, input logic rsh);
    @(negedge Clock);
    wr_en = we; wr_addr = wa; wr_data = wd;
    commit = c; sync = s; rd_sel = rs; rd_shadow = rsh;
    @(posedge Clock);
    for (int i = 0; i < 3; i++) model_step(i);
    #1;
    check_all();
  endtask

  task automatic idle();
    cycle(1'b0, 2'd0, 48'h0, 1'b0, 1'b0, 2'd0, 1'b0);
  endtask

  // Asynchronous reset in mid-cycle; outputs must clear without a clock edge.
  task automatic do_reset();
    @(negedge Clock);
    wr_en = 1'b0; commit = 1'b0; sync = 1'b0;
    #2;
    Reset = 1'b0;
    #1;
    check_eq("rst_dout0", dout0, 192'h0);
    check_eq("rst_pend0", 192'(pend0), 192'h0);
    check_eq("rst_upd0",  192'(upd0), 192'h0);
    check_eq("rst_rd0",   192'(rd0), 192'h0);
    check_eq("rst_dout1", dout1, 192'h0);
    check_eq("rst_dout2", 192'(dout2), 192'h0);
    check_eq("rst_rd2",   192'(rd2), 192'h0);
    model_clear();
    @(negedge Clock);
    Reset = 1'b1;
  endtask

  initial begin
    logic [63:0] rnd;
    Reset = 1'b0;
    wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    commit = 1'b0; sync = 1'b0; rd_sel = '0; rd_shadow = 1'b0;
    model_clear();
    #2;
    check_eq("por_dout0", dout0, 192'h0);
    check_eq("por_pend0", 192'(pend0), 192'h0);
    #20;
    Reset = 1'b1;

    // Deferred commit waits for Sync.
    cycle(1'b1, 2'd0, 48'h1234_5678_9ABC, 1'b0, 1'b0, 2'd0, 1'b0);
    cycle(1'b0, 2'd0, 48'h0, 1'b1, 1'b0, 2'd0, 1'b0);
    check_eq("d33_pend_on", 192'(pend0), 192'h1);
    for (int n = 0; n < 3; n++) begin
      idle();
      check_eq("d33_hold", 192'(dout0[47:0]), 192'h0);
    end
    cycle(1'b0, 2'd0, 48'h0, 1'b0, 1'b1, 2'd0, 1'b0);
    check_eq("d33_ch0", 192'(dout0[47:0]), 192'(48'h1234_5678_9ABC));
    check_eq("d33_pend_off", 192'(pend0), 192'h0);
    check_eq("d33_upd", 192'(upd0), 192'h1);
    idle();
    check_eq("d33_upd_end", 192'(upd0), 192'h0);

    // Commit and Sync together with a same-cycle write.
    cycle(1'b1, 2'd2, 48'hFFFF_0000_0001, 1'b1, 1'b1, 2'd0, 1'b0);
    check_eq("d34_ch2", 192'(dout0[2*48 +: 48]), 192'(48'hFFFF_0000_0001));
    check_eq("d34_pend", 192'(pend0), 192'h0);

    // Repeated Commit while armed collapses to one transfer.
    cycle(1'b0, 2'd0, 48'h0, 1'b1, 1'b0, 2'd0, 1'b0);
    cycle(1'b1, 2'd1, 48'h0000_0000_00AA, 1'b0, 1'b0, 2'd0, 1'b0);
    check_eq("d35_noupd", 192'(upd0), 192'h0);
    cycle(1'b0, 2'd0, 48'h0, 1'b1, 1'b0, 2'd0, 1'b0);
    check_eq("d35_noupd2", 192'(upd0), 192'h0);
    cycle(1'b0, 2'd0, 48'h0, 1'b0, 1'b1, 2'd0, 1'b0);
    check_eq("d35_upd", 192'(upd0), 192'h1);
    check_eq("d35_ch1", 192'(dout0[1*48 +: 48]), 192'(48'h0000_0000_00AA));
    idle();
    check_eq("d35_single", 192'(upd0), 192'h0);

    // Reset drops an armed commit.
    cycle(1'b0, 2'd0, 48'h0, 1'b1, 1'b0, 2'd0, 1'b0);
    check_eq("d36_armed", 192'(pend0), 192'h1);
    do_reset();
    idle();
    cycle(1'b0, 2'd0, 48'h0, 1'b0, 1'b1, 2'd0, 1'b0);
    check_eq("d36_dout", dout0, 192'h0);
    check_eq("d36_pend", 192'(pend0), 192'h0);
    check_eq("d36_upd", 192'(upd0), 192'h0);

    // Immediate mode: write plus Commit lands next cycle, never pending.
    cycle(1'b1, 2'd3, 48'h8000_0000_0000, 1'b1, 1'b0, 2'd0, 1'b0);
    check_eq("d37_ch3", 192'(dout1[3*48 +: 48]), 192'(48'h8000_0000_0000));
    check_eq("d37_pend", 192'(pend1), 192'h0);

    // Readback on the three-channel instance.
    do_reset();
    cycle(1'b1, 2'd1, 48'd5, 1'b0, 1'b0, 2'd0, 1'b0);
    cycle(1'b0, 2'd0, 48'h0, 1'b0, 1'b0, 2'd1, 1'b1);
    check_eq("d38_shadow", 192'(rd2), 192'd5);
    cycle(1'b0, 2'd0, 48'h0, 1'b0, 1'b0, 2'd1, 1'b0);
    check_eq("d38_active", 192'(rd2), 192'd0);
    cycle(1'b0, 2'd0, 48'h0, 1'b0, 1'b0, 2'd3, 1'b1);
    check_eq("d38_oor", 192'(rd2), 192'd0);

    // Randomized traffic against the model.
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 99) == 0) begin
        do_reset();
      end else begin
        rnd = {$urandom, $urandom};
        cycle(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), rnd[47:0],
              ($urandom_range(0, 5) == 0), ($urandom_range(0, 4) == 0),
              2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
